cu_fsm_irq: RTL and testbench
=============================

CU_FSM_IRQ -- requirements
Module: cu_fsm_irq

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 4, number of interrupt sources (1..8).
REQ-002 SHALL have parameter MULDIV_EN, default 1, enabling RV32M multi-cycle dispatch.
REQ-003 SHALL have parameter MULDIV_LAT, default 4, M-unit latency in cycles (1..15).
REQ-004 SHALL use one clock, CLK; reset RST is synchronous and active-high.
REQ-005 SHALL have ports, one per line (name, direction, width, meaning):
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- CU_OPCODE  in  7  instruction opcode
- FUNC3  in  3  instruction funct3
- FUNC7  in  7  instruction funct7
- BR_EQ, BR_LT, BR_LTU  in  1 each  branch comparator flags
- IRQ  in  NUM_IRQ  interrupt request lines, level, CLK-synchronous
- CSR_MIE  in  1  global interrupt enable
- PC_WRITE, REG_WRITE, MEM_WE2, MEM_RDEN1, MEM_RDEN2, CSR_WE  out  1 each  datapath strobes
- INT_TAKEN  out  1  interrupt entry pulse
- MRET_EXEC  out  1  mret executed pulse
- MD_START  out  1  M-unit start pulse
- ILLEGAL_OP  out  1  unknown-opcode pulse
- IRQ_ID  out  3  index of the interrupt being taken
- ALU_FUN  out  5  ALU op; bit4 selects M-unit
- ALU_SRCA  out  1, ALU_SRCB  out  2, PC_SOURCE  out  3, RF_WR_SEL  out  2  datapath muxes

Function
REQ-006 SHALL implement states FETCH, EXEC, WB, MD_WAIT, INTR; reset state FETCH.
REQ-007 FETCH SHALL assert MEM_RDEN1 and go to EXEC next cycle.
REQ-008 EXEC SHALL decode: LOAD -> MEM_RDEN2, go to WB; STORE -> MEM_WE2, PC_WRITE; OP with FUNC7=0000001 and MULDIV_EN=1 -> MD_START, go to MD_WAIT; all other legal opcodes -> PC_WRITE, REG_WRITE (except BRANCH, STORE, mret).
REQ-009 Mux encodings SHALL be: PC_SOURCE 0 PC+4, 1 JALR, 2 branch, 3 JAL, 4 mtvec, 5 mepc; RF_WR_SEL 0 PC+4, 1 CSR, 2 memory, 3 ALU.
REQ-010 ALU_FUN SHALL be {1'b0,FUNC7[5],FUNC3} for OP, for OP_IMM when FUNC3=101, else {2'b00,FUNC3}; {2'b10,FUNC3} for M ops; LUI 9 with ALU_SRCA=1; AUIPC ALU_SRCA=1, ALU_SRCB=3; LOAD ALU_SRCB=1; STORE ALU_SRCB=2.
REQ-011 BRANCH SHALL select PC_SOURCE=2 when taken (BEQ/BNE/BLT/BGE/BLTU/BGEU on BR_EQ/BR_LT/BR_LTU), else 0.
REQ-012 SYSTEM FUNC3=000 SHALL assert MRET_EXEC, PC_SOURCE=5, PC_WRITE; FUNC3=001 SHALL assert CSR_WE and REG_WRITE with RF_WR_SEL=1.
REQ-013 Unknown opcode SHALL pulse ILLEGAL_OP for one EXEC cycle, assert PC_WRITE with PC_SOURCE=0, no other strobe.
REQ-014 WB SHALL assert REG_WRITE, RF_WR_SEL=2, PC_WRITE.
REQ-015 MD_WAIT SHALL load a down-counter with MULDIV_LAT-1 on entry and stay until it reaches 0; in that last cycle assert REG_WRITE, RF_WR_SEL=3, PC_WRITE; MD_WAIT occupies exactly MULDIV_LAT cycles.
REQ-016 Each IRQ bit SHALL set a pending bit on its 0->1 edge (one-cycle-delayed sample); pending bits persist while CSR_MIE=0.
REQ-017 On leaving EXEC, WB or MD_WAIT toward FETCH, if CSR_MIE=1 and any pending bit set, SHALL go to INTR instead; mret cycles excluded.
REQ-018 INTR SHALL assert INT_TAKEN, PC_WRITE, PC_SOURCE=4, IRQ_ID = lowest set pending index, clear that bit, then go to FETCH.
REQ-019 Simultaneous set-edge and clear of the same pending bit SHALL leave it set.
REQ-020 Unlisted strobes SHALL be 0 and muxes 0 in every state.

Reset
REQ-021 RST high at a rising edge SHALL force state FETCH, counter 0, pending bits and edge samples 0, from any state including MD_WAIT.
REQ-022 While RST is high every output SHALL be 0, MEM_RDEN1 included.

Structure
REQ-023 Opcode enum, state enum, PC_SOURCE and RF_WR_SEL encodings SHALL live in shared package otter_pkg.
REQ-024 Interrupt pending/priority logic SHALL be sub-module irq_pend (parameter NUM_IRQ).

Verification
REQ-025 ADD x: FETCH, EXEC cycles; EXEC shows ALU_FUN=00000, REG_WRITE=1, PC_WRITE=1, RF_WR_SEL=3.
REQ-026 LW: three cycles; EXEC MEM_RDEN2=1, WB REG_WRITE=1, RF_WR_SEL=2, PC_WRITE=1.
REQ-027 MUL, MULDIV_LAT=4: MD_START one cycle, REG_WRITE only on 4th MD_WAIT cycle, ALU_FUN=10000.
REQ-028 IRQ=0101 edge during BEQ with BR_EQ=1, CSR_MIE=1: EXEC PC_SOURCE=2, then INTR IRQ_ID=0 PC_SOURCE=4; next eligible boundary IRQ_ID=2.
REQ-029 CSR_MIE=0 with IRQ[1] edge: no INTR; raise CSR_MIE -> INTR IRQ_ID=1 at next boundary.
REQ-030 RST mid-MD_WAIT: next cycle FETCH, counter 0, no REG_WRITE; opcode 7'b1111111 pulses ILLEGAL_OP once.

Source files
------------

// File: rtl/cu_fsm_irq_pkg.sv
// Shared encodings for the OTTER control unit: opcodes, FSM states, mux selects
// and the bundled control word the FSM drives.
package otter_pkg;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_EXEC    = 3'd1,
    ST_WB      = 3'd2,
    ST_MD_WAIT = 3'd3,
    ST_INTR    = 3'd4
  } state_e;

  localparam logic [2:0] PCS_PC4    = 3'd0;
  localparam logic [2:0] PCS_JALR   = 3'd1;
  localparam logic [2:0] PCS_BRANCH = 3'd2;
  localparam logic [2:0] PCS_JAL    = 3'd3;
  localparam logic [2:0] PCS_MTVEC  = 3'd4;
  localparam logic [2:0] PCS_MEPC   = 3'd5;

  localparam logic [1:0] RF_PC4 = 2'd0;
  localparam logic [1:0] RF_CSR = 2'd1;
  localparam logic [1:0] RF_MEM = 2'd2;
  localparam logic [1:0] RF_ALU = 2'd3;

  localparam int IRQ_ID_W = 3;

  typedef struct packed {
    logic                pc_write;
    logic                reg_write;
    logic                mem_we2;
    logic                mem_rden1;
    logic                mem_rden2;
    logic                csr_we;
    logic                int_taken;
    logic                mret_exec;
    logic                md_start;
    logic                illegal_op;
    logic [IRQ_ID_W-1:0] irq_id;
    logic [4:0]          alu_fun;
    logic                alu_srca;
    logic [1:0]          alu_srcb;
    logic [2:0]          pc_source;
    logic [1:0]          rf_wr_sel;
  } ctrl_t;

  function automatic logic br_taken(input logic [2:0] f3, input logic eq,
                                    input logic lt, input logic ltu);
    case (f3)
      3'b000:  return eq;
      3'b001:  return !eq;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cu_fsm_irq_pend.sv
// Interrupt pending latch: rising-edge capture per line, lowest-index priority,
// and clear of the granted bit (a coincident new edge wins over the clear).
module irq_pend import otter_pkg::*; #(
  parameter int NUM_IRQ = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_IRQ-1:0]  irq_i,
  input  logic                clr_i,
  output logic                any_o,
  output logic [IRQ_ID_W-1:0] id_o
);

  logic [NUM_IRQ-1:0] irq_q, pend_q, pend_d, clr_mask;

  always_comb begin
    id_o = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend_q[i]) id_o = IRQ_ID_W'(i);
    end
  end

  assign any_o    = |pend_q;
  assign clr_mask = clr_i ? (NUM_IRQ'(1) << id_o) : '0;
  assign pend_d   = (pend_q & ~clr_mask) | (irq_i & ~irq_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      irq_q  <= '0;
      pend_q <= '0;
    end else begin
      irq_q  <= irq_i;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/cu_fsm_irq.sv
// Multi-cycle RV32 control unit FSM with optional M-unit wait and vectored
// interrupt entry taken at instruction boundaries.
module cu_fsm_irq import otter_pkg::*; #(
  parameter int NUM_IRQ    = 4,
  parameter bit MULDIV_EN  = 1'b1,
  parameter int MULDIV_LAT = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [6:0]         CU_OPCODE,
  input  logic [2:0]         FUNC3,
  input  logic [6:0]         FUNC7,
  input  logic               BR_EQ,
  input  logic               BR_LT,
  input  logic               BR_LTU,
  input  logic [NUM_IRQ-1:0] IRQ,
  input  logic               CSR_MIE,
  output logic               PC_WRITE,
  output logic               REG_WRITE,
  output logic               MEM_WE2,
  output logic               MEM_RDEN1,
  output logic               MEM_RDEN2,
  output logic               CSR_WE,
  output logic               INT_TAKEN,
  output logic               MRET_EXEC,
  output logic               MD_START,
  output logic               ILLEGAL_OP,
  output logic [2:0]         IRQ_ID,
  output logic [4:0]         ALU_FUN,
  output logic               ALU_SRCA,
  output logic [1:0]         ALU_SRCB,
  output logic [2:0]         PC_SOURCE,
  output logic [1:0]         RF_WR_SEL
);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  ctrl_t                 ctrl, out;
  logic                  boundary, irq_any;
  logic [IRQ_ID_W-1:0]   irq_id;
  opcode_e               opc;

  assign opc = opcode_e'(CU_OPCODE);

  irq_pend #(.NUM_IRQ(NUM_IRQ)) u_irq_pend (
    .CLK   (CLK),
    .RST   (RST),
    .irq_i (IRQ),
    .clr_i (state_q == ST_INTR),
    .any_o (irq_any),
    .id_o  (irq_id)
  );

  always_comb begin
    ctrl     = '0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    boundary = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ctrl.mem_rden1 = 1'b1;
        state_d        = ST_EXEC;
      end
      ST_EXEC: begin
        boundary = 1'b1;
        case (opc)
          OPC_LOAD: begin
            ctrl.mem_rden2 = 1'b1;
            ctrl.alu_srcb  = 2'd1;
            boundary       = 1'b0;
            state_d        = ST_WB;
          end
          OPC_STORE: begin
            ctrl.mem_we2  = 1'b1;
            ctrl.pc_write = 1'b1;
            ctrl.alu_srcb = 2'd2;
          end
          OPC_OP: begin
            if (MULDIV_EN && FUNC7 == 7'b0000001) begin
              ctrl.md_start = 1'b1;
              ctrl.alu_fun  = {2'b10, FUNC3};
              boundary      = 1'b0;
              cnt_d         = 4'(MULDIV_LAT - 1);
              state_d       = ST_MD_WAIT;
            end else begin
              {ctrl.pc_write, ctrl.reg_write} = 2'b11;
              ctrl.alu_fun   = {1'b0, FUNC7[5], FUNC3};
              ctrl.rf_wr_sel = RF_ALU;
            end
          end
          OPC_OP_IMM: begin
            {ctrl.pc_write, ctrl.reg_write} = 2'b11;
            ctrl.alu_fun   = (FUNC3 == 3'b101) ? {1'b0, FUNC7[5], FUNC3} : {2'b00, FUNC3};
            ctrl.alu_srcb  = 2'd1;
            ctrl.rf_wr_sel = RF_ALU;
          end
          OPC_LUI: begin
            {ctrl.pc_write, ctrl.reg_write} = 2'b11;
            ctrl.alu_fun   = 5'd9;
            ctrl.alu_srca  = 1'b1;
            ctrl.rf_wr_sel = RF_ALU;
          end
          OPC_AUIPC: begin
            {ctrl.pc_write, ctrl.reg_write} = 2'b11;
            ctrl.alu_srca  = 1'b1;
            ctrl.alu_srcb  = 2'd3;
            ctrl.rf_wr_sel = RF_ALU;
          end
          OPC_JAL: begin
            {ctrl.pc_write, ctrl.reg_write} = 2'b11;
            ctrl.pc_source = PCS_JAL;
            ctrl.rf_wr_sel = RF_PC4;
          end
          OPC_JALR: begin
            {ctrl.pc_write, ctrl.reg_write} = 2'b11;
            ctrl.pc_source = PCS_JALR;
            ctrl.rf_wr_sel = RF_PC4;
          end
          OPC_BRANCH: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = br_taken(FUNC3, BR_EQ, BR_LT, BR_LTU) ? PCS_BRANCH : PCS_PC4;
          end
          OPC_SYSTEM: begin
            ctrl.pc_write = 1'b1;
            if (FUNC3 == 3'b000) begin
              // mret returns straight to mepc; never divert it into a new trap
              ctrl.mret_exec = 1'b1;
              ctrl.pc_source = PCS_MEPC;
              boundary       = 1'b0;
              state_d        = ST_FETCH;
            end else begin
              ctrl.reg_write = 1'b1;
              ctrl.csr_we    = (FUNC3 == 3'b001);
              ctrl.rf_wr_sel = RF_CSR;
            end
          end
          default: begin
            ctrl.illegal_op = 1'b1;
            ctrl.pc_write   = 1'b1;
          end
        endcase
      end
      ST_WB: begin
        {ctrl.pc_write, ctrl.reg_write} = 2'b11;
        ctrl.rf_wr_sel = RF_MEM;
        boundary       = 1'b1;
      end
      ST_MD_WAIT: begin
        if (cnt_q == 4'd0) begin
          {ctrl.pc_write, ctrl.reg_write} = 2'b11;
          ctrl.rf_wr_sel = RF_ALU;
          boundary       = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_INTR: begin
        ctrl.int_taken = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_MTVEC;
        ctrl.irq_id    = irq_id;
        state_d        = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
    if (boundary) state_d = (CSR_MIE && irq_any) ? ST_INTR : ST_FETCH;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out = RST ? '0 : ctrl;
  assign {PC_WRITE, REG_WRITE, MEM_WE2, MEM_RDEN1, MEM_RDEN2, CSR_WE, INT_TAKEN,
          MRET_EXEC, MD_START, ILLEGAL_OP, IRQ_ID, ALU_FUN, ALU_SRCA, ALU_SRCB,
          PC_SOURCE, RF_WR_SEL} = out;

endmodule

// File: tb/tb_cu_fsm_irq.sv
// Self-checking bench for cu_fsm_irq: directed scenarios then a random
// instruction stream, each cycle compared to an instruction-level model.
module tb_cu_fsm_irq;

  localparam int LAT = 4;

  logic       CLK = 1'b0, RST = 1'b1;
  logic [6:0] CU_OPCODE = '0, FUNC7 = '0;
  logic [2:0] FUNC3 = '0;
  logic       BR_EQ = 0, BR_LT = 0, BR_LTU = 0, CSR_MIE = 0;
  logic [3:0] IRQ = '0;
  logic PC_WRITE, REG_WRITE, MEM_WE2, MEM_RDEN1, MEM_RDEN2, CSR_WE, INT_TAKEN;
  logic MRET_EXEC, MD_START, ILLEGAL_OP, ALU_SRCA;
  logic [2:0] IRQ_ID, PC_SOURCE;
  logic [4:0] ALU_FUN;
  logic [1:0] ALU_SRCB, RF_WR_SEL;

  cu_fsm_irq #(.NUM_IRQ(4), .MULDIV_EN(1'b1), .MULDIV_LAT(LAT)) dut (
    .CLK(CLK), .RST(RST), .CU_OPCODE(CU_OPCODE), .FUNC3(FUNC3), .FUNC7(FUNC7),
    .BR_EQ(BR_EQ), .BR_LT(BR_LT), .BR_LTU(BR_LTU), .IRQ(IRQ), .CSR_MIE(CSR_MIE),
    .PC_WRITE(PC_WRITE), .REG_WRITE(REG_WRITE), .MEM_WE2(MEM_WE2), .MEM_RDEN1(MEM_RDEN1),
    .MEM_RDEN2(MEM_RDEN2), .CSR_WE(CSR_WE), .INT_TAKEN(INT_TAKEN), .MRET_EXEC(MRET_EXEC),
    .MD_START(MD_START), .ILLEGAL_OP(ILLEGAL_OP), .IRQ_ID(IRQ_ID), .ALU_FUN(ALU_FUN),
    .ALU_SRCA(ALU_SRCA), .ALU_SRCB(ALU_SRCB), .PC_SOURCE(PC_SOURCE), .RF_WR_SEL(RF_WR_SEL)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic pcw, rw, we2, rd1, rd2, csrwe, intt, mret, mds, ill;
    logic [2:0] id;
    logic srca;
    logic [1:0] srcb;
    logic [2:0] pcs;
    logic [1:0] rfs;
  } outs_t;

  typedef enum int {K_PLAIN, K_LOAD, K_MD, K_MRET} kind_e;

  outs_t obs;
  assign obs = {PC_WRITE, REG_WRITE, MEM_WE2, MEM_RDEN1, MEM_RDEN2, CSR_WE, INT_TAKEN,
                MRET_EXEC, MD_START, ILLEGAL_OP, IRQ_ID, ALU_SRCA, ALU_SRCB, PC_SOURCE, RF_WR_SEL};

  int n_tests = 0, n_fail = 0;
  logic [3:0] m_pend = '0, m_prev = '0, m_clr = '0;

  task automatic chk(input string tag, input outs_t e);
    n_tests++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic chk_alu(input string tag, input logic [4:0] e);
    n_tests++;
    assert (ALU_FUN === e) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, ALU_FUN, e);
    end
  endtask

  task automatic chk_id(input string tag, input int got, input int want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  // Advance one clock and update the pending-interrupt model with what the
  // inputs were at that edge.
  task automatic cyc();
    @(posedge CLK);
    if (RST) begin
      m_pend = '0;
      m_prev = '0;
    end else begin
      m_pend = (m_pend & ~m_clr) | (IRQ & ~m_prev);
      m_prev = IRQ;
    end
    m_clr = '0;
    #1;
  endtask

  function automatic void exec_exp(input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic eq, input logic lt, input logic ltu,
      output outs_t e, output logic [4:0] alu, output bit alu_chk, output kind_e kind);
    bit tk;
    e = '0; alu = '0; alu_chk = 0; kind = K_PLAIN;
    case (op)
      7'b0110111: begin e.rw = 1; e.pcw = 1; e.srca = 1; e.rfs = 3; alu = 5'd9; alu_chk = 1; end
      7'b0010111: begin e.rw = 1; e.pcw = 1; e.srca = 1; e.srcb = 3; e.rfs = 3; end
      7'b1101111: begin e.rw = 1; e.pcw = 1; e.pcs = 3; end
      7'b1100111: begin e.rw = 1; e.pcw = 1; e.pcs = 1; end
      7'b1100011: begin
        tk = (f3 == 0 && eq) || (f3 == 1 && !eq) || (f3 == 4 && lt) ||
             (f3 == 5 && !lt) || (f3 == 6 && ltu) || (f3 == 7 && !ltu);
        e.pcw = 1; e.pcs = tk ? 3'd2 : 3'd0;
      end
      7'b0000011: begin e.rd2 = 1; e.srcb = 1; kind = K_LOAD; end
      7'b0100011: begin e.we2 = 1; e.pcw = 1; e.srcb = 2; end
      7'b0010011: begin
        e.rw = 1; e.pcw = 1; e.srcb = 1; e.rfs = 3; alu_chk = 1;
        alu = (f3 == 3'b101) ? {1'b0, f7[5], f3} : {2'b00, f3};
      end
      7'b0110011: begin
        alu_chk = 1;
        if (f7 == 7'b0000001) begin e.mds = 1; alu = {2'b10, f3}; kind = K_MD; end
        else begin e.rw = 1; e.pcw = 1; e.rfs = 3; alu = {1'b0, f7[5], f3}; end
      end
      7'b1110011: begin
        if (f3 == 0) begin e.mret = 1; e.pcs = 5; e.pcw = 1; kind = K_MRET; end
        else begin e.csrwe = 1; e.rw = 1; e.rfs = 1; e.pcw = 1; end
      end
      default: begin e.ill = 1; e.pcw = 1; end
    endcase
  endfunction

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
      input logic eq, input logic lt, input logic ltu, input logic [3:0] irq,
      input logic mie, output int taken);
    outs_t e; logic [4:0] alu; bit alu_chk; kind_e kind; bit go_int; int id;
    taken = -1;
    CU_OPCODE = op; FUNC3 = f3; FUNC7 = f7; BR_EQ = eq; BR_LT = lt; BR_LTU = ltu;
    IRQ = irq; CSR_MIE = mie;
    @(negedge CLK);
    e = '0; e.rd1 = 1;
    chk("fetch", e); chk_alu("fetch_alu", 5'd0);
    cyc();
    exec_exp(op, f3, f7, eq, lt, ltu, e, alu, alu_chk, kind);
    @(negedge CLK);
    chk($sformatf("exec_op%b_f3%0d", op, f3), e);
    if (alu_chk) chk_alu($sformatf("exec_alu_op%b", op), alu);
    go_int = mie && (m_pend != 0) && (kind != K_MRET);
    cyc();
    if (kind == K_LOAD) begin
      @(negedge CLK);
      e = '0; e.rw = 1; e.rfs = 2; e.pcw = 1;
      chk("wb", e);
      go_int = mie && (m_pend != 0);
      cyc();
    end else if (kind == K_MD) begin
      for (int k = 1; k <= LAT; k++) begin
        @(negedge CLK);
        e = '0;
        if (k == LAT) begin e.rw = 1; e.rfs = 3; e.pcw = 1; end
        chk($sformatf("md_wait_%0d", k), e);
        go_int = mie && (m_pend != 0);
        cyc();
      end
    end
    if (go_int) begin
      id = 0;
      for (int i = 3; i >= 0; i--) if (m_pend[i]) id = i;
      @(negedge CLK);
      e = '0; e.intt = 1; e.pcw = 1; e.pcs = 4; e.id = 3'(id);
      chk("intr", e);
      m_clr = 4'(1 << id);
      cyc();
      taken = id;
    end
  endtask

  initial begin
    int t;
    outs_t e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [3:0] irq_r;
    logic [6:0] illegal_ops [3];
    logic [2:0] br_f3 [6];
    illegal_ops = '{7'h7f, 7'h0b, 7'h00};
    br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    // Reset: every output low, MEM_RDEN1 included
    RST = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK); chk("reset_outs", '0); chk_alu("reset_alu", 5'd0); cyc();
    end
    RST = 0;

    run_instr(7'b0110011, 3'd0, 7'd0, 0, 0, 0, 4'b0000, 1, t);      // ADD
    run_instr(7'b0000011, 3'd2, 7'd0, 0, 0, 0, 4'b0000, 1, t);      // LW
    run_instr(7'b0110011, 3'd0, 7'b0000001, 0, 0, 0, 4'b0000, 1, t); // MUL
    run_instr(7'b0110011, 3'd5, 7'b0100000, 0, 0, 0, 4'b0000, 1, t); // SRA

    // Two simultaneous edges during a taken BEQ, served lowest index first
    run_instr(7'b1100011, 3'd0, 7'd0, 1, 0, 0, 4'b0101, 1, t);
    chk_id("beq_irq_first", t, 0);
    run_instr(7'b0110011, 3'd0, 7'd0, 0, 0, 0, 4'b0101, 1, t);
    chk_id("beq_irq_second", t, 2);

    // Masked edge stays pending until CSR_MIE is raised
    run_instr(7'b0010011, 3'd1, 7'd0, 0, 0, 0, 4'b0010, 0, t);
    chk_id("mie_off_no_intr", t, -1);
    run_instr(7'b0110011, 3'd0, 7'd0, 0, 0, 0, 4'b0010, 1, t);
    chk_id("mie_on_intr", t, 1);

    // mret with a pending request goes straight back to fetch
    run_instr(7'b1110011, 3'd0, 7'd0, 0, 0, 0, 4'b1010, 1, t);
    chk_id("mret_no_intr", t, -1);
    run_instr(7'b1110011, 3'd1, 7'd0, 0, 0, 0, 4'b1010, 1, t);
    chk_id("csr_then_intr", t, 3);

    // Reset in the middle of the M-unit wait
    IRQ = '0; CSR_MIE = 1; CU_OPCODE = 7'b0110011; FUNC3 = 3'd0; FUNC7 = 7'b0000001;
    @(negedge CLK); e = '0; e.rd1 = 1; chk("r_fetch", e); cyc();
    @(negedge CLK); e = '0; e.mds = 1; chk("r_exec", e); cyc();
    @(negedge CLK); chk("r_md1", '0); cyc();
    RST = 1;
    @(negedge CLK); chk("r_rst_outs", '0); cyc();
    RST = 0;
    run_instr(7'b0110011, 3'd1, 7'b0000001, 0, 0, 0, 4'b0000, 1, t); // full latency again
    run_instr(7'b1111111, 3'd0, 7'd0, 0, 0, 0, 4'b0000, 1, t);       // illegal

    // Random instruction stream with random interrupt activity
    irq_r = '0;
    for (int n = 0; n < 400; n++) begin
      f3 = 3'($urandom_range(0, 7));
      f7 = 7'd0;
      case ($urandom_range(0, 10))
        0: op = 7'b0110111;
        1: op = 7'b0010111;
        2: op = 7'b1101111;
        3: op = 7'b1100111;
        4: begin op = 7'b1100011; f3 = br_f3[$urandom_range(0, 5)]; end
        5: op = 7'b0000011;
        6: op = 7'b0100011;
        7: begin op = 7'b0010011; f7 = ($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'd0; end
        8: begin
          op = 7'b0110011;
          case ($urandom_range(0, 2))
            0: f7 = 7'd0;
            1: f7 = 7'b0100000;
            default: f7 = 7'b0000001;
          endcase
        end
        9: begin op = 7'b1110011; f3 = 3'($urandom_range(0, 1)); end
        default: op = illegal_ops[$urandom_range(0, 2)];
      endcase
      if ($urandom_range(0, 3) == 0) irq_r = 4'($urandom_range(0, 15));
      run_instr(op, f3, f7, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), irq_r, ($urandom_range(0, 3) != 0), t);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
